// File: rtl/prbs_pattern_checker.sv
// -----------------------------------------------------------------------------
// prbs_pattern_checker
//
// Purpose:
//   Captures a reference pattern of PAT_LEN words after a START pulse, then
//   checks the incoming stream against it. The block resynchronises on any
//   mismatch. It declares success after N_PATTERN consecutive clean
//   repetitions. It declares failure when the mismatch count reaches MAX_ERR,
//   where MAX_ERR = 0 means there is no limit.
//
// Ports:
//   CLK            clock, rising edge
//   RST            asynchronous reset, active low
//   CLR            synchronous clear back to IDLE (highest priority)
//   START          one-cycle pulse: latch N_PATTERN/MAX_ERR, begin capture
//   IN_VALID       qualifies IN
//   IN             data word under test
//   N_PATTERN      clean repetitions required (latched on START)
//   MAX_ERR        mismatch limit, 0 = unlimited (latched on START)
//   BUSY           high while capturing or checking
//   PATTERN_FOUND  sticky success flag
//   PATTERN_FAIL   sticky failure flag
//   REP_CNT        consecutive matching repetitions completed
//   ERR_CNT        mismatching words since START, saturating
// -----------------------------------------------------------------------------
module prbs_pattern_checker #(
  parameter int DATA_W  = 8,
  parameter int PAT_LEN = 4,
  parameter int CNT_W   = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CLR,
  input  logic              START,
  input  logic              IN_VALID,
  input  logic [DATA_W-1:0] IN,
  input  logic [CNT_W-1:0]  N_PATTERN,
  input  logic [CNT_W-1:0]  MAX_ERR,
  output logic              BUSY,
  output logic              PATTERN_FOUND,
  output logic              PATTERN_FAIL,
  output logic [CNT_W-1:0]  REP_CNT,
  output logic [CNT_W-1:0]  ERR_CNT
);

  localparam int IDX_W = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_CHECK,
    S_FOUND,
    S_FAIL
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   rep_q, rep_d;
  logic [CNT_W-1:0]   err_q, err_d;
  logic [CNT_W-1:0]   npat_q, npat_d;
  logic [CNT_W-1:0]   maxerr_q, maxerr_d;
  logic               busy_q, busy_d;
  logic               found_q, found_d;
  logic               fail_q, fail_d;

  logic               pat_we;
  logic [DATA_W-1:0]  pat_q [PAT_LEN];

  logic               word_match;
  logic [CNT_W-1:0]   rep_inc;
  logic [CNT_W-1:0]   err_inc;

  assign word_match = (IN == pat_q[idx_q]);
  assign rep_inc    = rep_q + CNT_W'(1);
  // The error counter sticks at all-ones instead of wrapping.
  assign err_inc    = (&err_q) ? err_q : (err_q + CNT_W'(1));

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      rep_q    <= '0;
      err_q    <= '0;
      npat_q   <= '0;
      maxerr_q <= '0;
      busy_q   <= 1'b0;
      found_q  <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      rep_q    <= rep_d;
      err_q    <= err_d;
      npat_q   <= npat_d;
      maxerr_q <= maxerr_d;
      busy_q   <= busy_d;
      found_q  <= found_d;
      fail_q   <= fail_d;
    end
  end

  // The pattern store has no reset: its contents are always rewritten by
  // capture before they are compared.
  always_ff @(posedge CLK) begin
    if (pat_we) begin
      pat_q[idx_q] <= IN;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rep_d    = rep_q;
    err_d    = err_q;
    npat_d   = npat_q;
    maxerr_d = maxerr_q;
    pat_we   = 1'b0;

    if (CLR) begin
      state_d = S_IDLE;
      idx_d   = '0;
      rep_d   = '0;
      err_d   = '0;
    end else begin
      case (state_q)
        S_IDLE, S_FOUND, S_FAIL: begin
          if (START) begin
            state_d  = S_CAPTURE;
            npat_d   = N_PATTERN;
            maxerr_d = MAX_ERR;
            idx_d    = '0;
            rep_d    = '0;
            err_d    = '0;
          end
        end

        S_CAPTURE: begin
          if (IN_VALID) begin
            pat_we = 1'b1;
            if (idx_q == LAST_IDX) begin
              idx_d   = '0;
              // A zero repetition target is satisfied by the capture alone.
              state_d = (npat_q == '0) ? S_FOUND : S_CHECK;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end

        S_CHECK: begin
          if (IN_VALID) begin
            if (word_match) begin
              if (idx_q == LAST_IDX) begin
                idx_d = '0;
                rep_d = rep_inc;
                if (rep_inc == npat_q) begin
                  state_d = S_FOUND;
                end
              end else begin
                idx_d = idx_q + IDX_W'(1);
              end
            end else begin
              // Resync: drop the bad word and restart the pattern from slot 0.
              idx_d = '0;
              rep_d = '0;
              err_d = err_inc;
              if ((maxerr_q != '0) && (err_inc == maxerr_q)) begin
                state_d = S_FAIL;
              end
            end
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic. The outputs are decoded from the next state so that they
  // appear registered in the same cycle as the state they describe.
  // ---------------------------------------------------------------------------
  always_comb begin
    busy_d  = (state_d == S_CAPTURE) || (state_d == S_CHECK);
    found_d = (state_d == S_FOUND);
    fail_d  = (state_d == S_FAIL);
  end

  assign BUSY          = busy_q;
  assign PATTERN_FOUND = found_q;
  assign PATTERN_FAIL  = fail_q;
  assign REP_CNT       = rep_q;
  assign ERR_CNT       = err_q;

endmodule

// File: tb/tb_prbs_pattern_checker.sv
// -----------------------------------------------------------------------------
// tb_prbs_pattern_checker
//
// Purpose:
//   Directed, table-driven bench for prbs_pattern_checker with DATA_W = 8,
//   PAT_LEN = 4 and CNT_W = 8. Each record holds one cycle of inputs and the
//   outputs expected just after that rising edge. Hand-written sequences
//   cover the following cases:
//     - resync
//     - failure
//     - stall
//     - asynchronous abort
//     - clear
// -----------------------------------------------------------------------------
module tb_prbs_pattern_checker;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       CLR = 1'b0;
  logic       START = 1'b0;
  logic       IN_VALID = 1'b0;
  logic [7:0] IN = '0;
  logic [7:0] N_PATTERN = '0;
  logic [7:0] MAX_ERR = '0;
  logic       BUSY;
  logic       PATTERN_FOUND;
  logic       PATTERN_FAIL;
  logic [7:0] REP_CNT;
  logic [7:0] ERR_CNT;

  prbs_pattern_checker #(
    .DATA_W (8),
    .PAT_LEN(4),
    .CNT_W  (8)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .CLR          (CLR),
    .START        (START),
    .IN_VALID     (IN_VALID),
    .IN           (IN),
    .N_PATTERN    (N_PATTERN),
    .MAX_ERR      (MAX_ERR),
    .BUSY         (BUSY),
    .PATTERN_FOUND(PATTERN_FOUND),
    .PATTERN_FAIL (PATTERN_FAIL),
    .REP_CNT      (REP_CNT),
    .ERR_CNT      (ERR_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       clr;
    logic       start;
    logic       vld;
    logic [7:0] din;
    logic [7:0] npat;
    logic [7:0] maxerr;
    logic       e_busy;
    logic       e_found;
    logic       e_fail;
    logic [7:0] e_rep;
    logic [7:0] e_err;
  } vec_t;

  int total = 0;
  int bad   = 0;

  logic [7:0] pat [4];
  vec_t       vq [$];

  function automatic vec_t mk(input logic clr, input logic start, input logic vld,
                              input logic [7:0] din, input logic [7:0] npat,
                              input logic [7:0] maxerr, input logic eb,
                              input logic ef, input logic efl,
                              input logic [7:0] erep, input logic [7:0] eerr);
    vec_t v;
    v.clr = clr;  v.start = start;  v.vld = vld;  v.din = din;
    v.npat = npat;  v.maxerr = maxerr;
    v.e_busy = eb;  v.e_found = ef;  v.e_fail = efl;
    v.e_rep = erep;  v.e_err = eerr;
    return v;
  endfunction

  // Expected REP_CNT after n valid words, counting the capture words, of an
  // error-free stream.
  function automatic logic [7:0] clean_rep(input int n);
    return (n < 4) ? 8'd0 : 8'(n / 4 - 1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_now(input string tag, input int n, input logic eb, input logic ef,
                           input logic efl, input logic [7:0] erep, input logic [7:0] eerr);
    $display("%s[%0d] busy=%0b found=%0b fail=%0b rep=%0d err=%0d",
             tag, n, BUSY, PATTERN_FOUND, PATTERN_FAIL, REP_CNT, ERR_CNT);
    chk($sformatf("%s[%0d].busy", tag, n),  32'(BUSY),          32'(eb));
    chk($sformatf("%s[%0d].found", tag, n), 32'(PATTERN_FOUND), 32'(ef));
    chk($sformatf("%s[%0d].fail", tag, n),  32'(PATTERN_FAIL),  32'(efl));
    chk($sformatf("%s[%0d].rep", tag, n),   32'(REP_CNT),       32'(erep));
    chk($sformatf("%s[%0d].err", tag, n),   32'(ERR_CNT),       32'(eerr));
  endtask

  // Drives one record for one clock, samples 1 time unit after the edge, then
  // drops the pulse inputs.
  task automatic apply(input vec_t v, input string tag, input int n);
    @(negedge CLK);
    CLR = v.clr;  START = v.start;  IN_VALID = v.vld;  IN = v.din;
    N_PATTERN = v.npat;  MAX_ERR = v.maxerr;
    @(posedge CLK);
    #1;
    CLR = 1'b0;  START = 1'b0;  IN_VALID = 1'b0;
    check_now(tag, n, v.e_busy, v.e_found, v.e_fail, v.e_rep, v.e_err);
  endtask

  initial begin
    int       n;
    logic [7:0] x;

    pat[0] = 8'hA5;  pat[1] = 8'h3C;  pat[2] = 8'h0F;  pat[3] = 8'hF0;

    // ---- Table: pass case (N=3), then N=0 edge case and restart ----
    vq.push_back(mk(0, 1, 0, 8'h00, 8'd3, 8'd0, 1, 0, 0, 0, 0));
    for (int k = 1; k <= 16; k++) begin
      vq.push_back(mk(0, 0, 1, pat[(k - 1) % 4], 8'd3, 8'd0,
                      (k != 16), (k == 16), 0, clean_rep(k), 0));
    end
    // Input is ignored once FOUND has been reached.
    vq.push_back(mk(0, 0, 1, 8'h00, 8'd3, 8'd0, 0, 1, 0, 3, 0));
    vq.push_back(mk(0, 0, 1, 8'hA5, 8'd3, 8'd0, 0, 1, 0, 3, 0));
    vq.push_back(mk(0, 0, 0, 8'h00, 8'd3, 8'd0, 0, 1, 0, 3, 0));
    // A zero repetition target goes straight to FOUND after the capture.
    vq.push_back(mk(0, 1, 0, 8'h00, 8'd0, 8'd0, 1, 0, 0, 0, 0));
    for (int k = 1; k <= 4; k++) begin
      vq.push_back(mk(0, 0, 1, pat[k - 1], 8'd0, 8'd0, (k != 4), (k == 4), 0, 0, 0));
    end
    // A later START clears PATTERN_FOUND and captures again.
    vq.push_back(mk(0, 1, 0, 8'h00, 8'd3, 8'd0, 1, 0, 0, 0, 0));
    for (int k = 1; k <= 4; k++) begin
      vq.push_back(mk(0, 0, 1, pat[k - 1], 8'd3, 8'd0, 1, 0, 0, 0, 0));
    end
    vq.push_back(mk(0, 0, 1, 8'hA5, 8'd3, 8'd0, 1, 0, 0, 0, 0));
    vq.push_back(mk(1, 0, 0, 8'h00, 8'd3, 8'd0, 0, 0, 0, 0, 0));

    // ---- Reset state ----
    repeat (2) @(posedge CLK);
    #1;
    check_now("reset", 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    RST = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      apply(vq[i], "table", i);
    end

    // ---- Resync: one corrupted word in the second repetition ----
    apply(mk(0, 1, 0, 8'h00, 8'd3, 8'd0, 1, 0, 0, 0, 0), "resync", 0);
    for (int k = 1; k <= 8; k++) begin
      apply(mk(0, 0, 1, pat[(k - 1) % 4], 8'd3, 8'd0, 1, 0, 0, clean_rep(k), 0), "resync", k);
    end
    apply(mk(0, 0, 1, pat[0], 8'd3, 8'd0, 1, 0, 0, 1, 0), "resync", 9);
    apply(mk(0, 0, 1, pat[1], 8'd3, 8'd0, 1, 0, 0, 1, 0), "resync", 10);
    apply(mk(0, 0, 1, 8'h00,  8'd3, 8'd0, 1, 0, 0, 0, 1), "resync", 11);
    for (int k = 1; k <= 12; k++) begin
      apply(mk(0, 0, 1, pat[(k - 1) % 4], 8'd3, 8'd0, (k != 12), (k == 12), 0,
               8'(k / 4), 1), "resync", 11 + k);
    end

    // ---- Failure: MAX_ERR = 2 with non-matching data ----
    apply(mk(0, 1, 0, 8'h00, 8'd3, 8'd2, 1, 0, 0, 0, 0), "fail", 0);
    for (int k = 1; k <= 4; k++) begin
      apply(mk(0, 0, 1, pat[k - 1], 8'd3, 8'd2, 1, 0, 0, 0, 0), "fail", k);
    end
    x = 8'($urandom_range(0, 255));
    if (x == 8'hA5) x = 8'h5A;
    apply(mk(0, 0, 1, x, 8'd3, 8'd2, 1, 0, 0, 0, 1), "fail", 5);
    x = 8'($urandom_range(0, 255));
    if (x == 8'hA5) x = 8'h5A;
    apply(mk(0, 0, 1, x, 8'd3, 8'd2, 0, 0, 1, 0, 2), "fail", 6);
    apply(mk(0, 0, 1, 8'h00, 8'd3, 8'd2, 0, 0, 1, 0, 2), "fail", 7);

    // ---- Stall: IN_VALID alternates, so throughput is halved ----
    apply(mk(0, 1, 0, 8'h00, 8'd3, 8'd0, 1, 0, 0, 0, 0), "stall", 0);
    n = 0;
    for (int k = 0; k < 32; k++) begin
      if ((k % 2) == 0) n++;
      apply(mk(0, 0, ((k % 2) == 0), pat[(n - 1) % 4], 8'd3, 8'd0,
               (n != 16), (n == 16), 0, clean_rep(n), 0), "stall", k + 1);
    end

    // ---- Abort: asynchronous reset in the middle of CHECK ----
    apply(mk(0, 1, 0, 8'h00, 8'd3, 8'd0, 1, 0, 0, 0, 0), "abort", 0);
    for (int k = 1; k <= 9; k++) begin
      apply(mk(0, 0, 1, pat[(k - 1) % 4], 8'd3, 8'd0, 1, 0, 0, clean_rep(k), 0), "abort", k);
    end
    @(negedge CLK);
    #2;
    RST = 1'b0;
    #1;
    check_now("abort_rst", 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    RST = 1'b1;
    // Without a new START the block stays idle.
    for (int k = 1; k <= 4; k++) begin
      apply(mk(0, 0, 1, pat[k - 1], 8'd3, 8'd0, 0, 0, 0, 0, 0), "post_rst", k);
    end

    // ---- CLR together with START and IN_VALID ----
    apply(mk(0, 1, 0, 8'h00, 8'd3, 8'd0, 1, 0, 0, 0, 0), "clr", 0);
    for (int k = 1; k <= 8; k++) begin
      apply(mk(0, 0, 1, pat[(k - 1) % 4], 8'd3, 8'd0, 1, 0, 0, clean_rep(k), 0), "clr", k);
    end
    apply(mk(0, 0, 1, 8'h77, 8'd3, 8'd0, 1, 0, 0, 0, 1), "clr", 9);
    apply(mk(1, 1, 1, 8'hA5, 8'd3, 8'd0, 0, 0, 0, 0, 0), "clr", 10);
    apply(mk(0, 0, 0, 8'h00, 8'd3, 8'd0, 0, 0, 0, 0, 0), "clr", 11);
    apply(mk(0, 0, 1, 8'hA5, 8'd3, 8'd0, 0, 0, 0, 0, 0), "clr", 12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
